// File: rtl/microwave_pkg.sv
// Shared types and limits for the microwave countdown timer (M:TS BCD count).
// Pure declarations: no logic, no latency, no flow control.
package microwave_pkg;

  localparam int MAX_TENS         = 5;
  localparam int MAX_DIGIT        = 9;
  localparam int DEFAULT_ADD_SECS = 30;
  localparam int MAX_TOTAL_SECS   = 599;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] mins;
    logic [3:0] tens;
    logic [3:0] secs;
  } mmss_t;

  function automatic logic [3:0] sat_digit(input logic [3:0] d, input int lim);
    return (d > 4'(lim)) ? 4'(lim) : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control inputs and BCD display outputs of the countdown timer.
// master drives the controls; slave is the timer itself.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic [3:0] din_min;
  logic [3:0] din_ten;
  logic [3:0] din_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic       add30;
  logic [3:0] mins;
  logic [3:0] tens;
  logic [3:0] secs;
  logic       running;
  logic       done;

  modport master (
    output tick, load, din_min, din_ten, din_sec, start, pause, clear, add30,
    input  mins, tens, secs, running, done
  );

  modport slave (
    input  tick, load, din_min, din_ten, din_sec, start, pause, clear, add30,
    output mins, tens, secs, running, done
  );
endinterface

// File: rtl/mmss_arith.sv
// Combinational M:TS arithmetic: decrement by one second, saturating add of ADD_SECS, zero flags.
// Zero latency, no handshake.
module mmss_arith
  import microwave_pkg::*;
#(
  parameter int ADD_SECS = DEFAULT_ADD_SECS
) (
  input  mmss_t cnt_i,
  output mmss_t dec_o,
  output mmss_t add_o,
  output logic  zero_o,
  output logic  dec_zero_o
);

  logic [9:0]  total_secs;
  logic [10:0] sum_secs;
  logic [9:0]  sat_secs;
  logic [9:0]  rem_secs;

  assign zero_o = (cnt_i == '0);

  // Borrow ripples secs -> tens -> mins; 0:00 holds rather than wrapping.
  always_comb begin
    dec_o = cnt_i;
    if (!zero_o) begin
      if (cnt_i.secs != 4'd0) begin
        dec_o.secs = cnt_i.secs - 4'd1;
      end else begin
        dec_o.secs = 4'(MAX_DIGIT);
        if (cnt_i.tens != 4'd0) begin
          dec_o.tens = cnt_i.tens - 4'd1;
        end else begin
          dec_o.tens = 4'(MAX_TENS);
          dec_o.mins = cnt_i.mins - 4'd1;
        end
      end
    end
  end

  assign dec_zero_o = (dec_o == '0);

  // The add goes through a binary seconds total so any ADD_SECS carries correctly.
  assign total_secs = 10'(cnt_i.mins) * 10'd60 + 10'(cnt_i.tens) * 10'd10 + 10'(cnt_i.secs);
  assign sum_secs   = {1'b0, total_secs} + 11'(ADD_SECS);
  assign sat_secs   = (sum_secs > 11'(MAX_TOTAL_SECS)) ? 10'(MAX_TOTAL_SECS) : sum_secs[9:0];
  assign rem_secs   = sat_secs % 10'd60;

  always_comb begin
    add_o      = '0;
    add_o.mins = 4'(sat_secs / 10'd60);
    add_o.tens = 4'(rem_secs / 10'd10);
    add_o.secs = 4'(rem_secs % 10'd10);
  end

endmodule

// File: rtl/countdown_timer.sv
// Microwave countdown timer: IDLE/RUN/PAUSE/DONE FSM over a registered M:TS BCD count.
// One-cycle latency from sampled control to outputs; controls are level-sampled, never stalled.
module countdown_timer
  import microwave_pkg::*;
#(
  parameter int ADD_SECS = DEFAULT_ADD_SECS
) (
  input  logic                clk,
  input  logic                rst_n,
  countdown_timer_if.slave    bus
);

  state_t state_q, state_d;
  mmss_t  cnt_q, cnt_d;
  logic   running_q, running_d;
  logic   done_q, done_d;

  mmss_t  dec_cnt;
  mmss_t  add_cnt;
  mmss_t  load_cnt;
  logic   cnt_zero;
  logic   dec_zero;

  mmss_arith #(
    .ADD_SECS (ADD_SECS)
  ) u_arith (
    .cnt_i      (cnt_q),
    .dec_o      (dec_cnt),
    .add_o      (add_cnt),
    .zero_o     (cnt_zero),
    .dec_zero_o (dec_zero)
  );

  always_comb begin
    load_cnt      = '0;
    load_cnt.mins = sat_digit(bus.din_min, MAX_DIGIT);
    load_cnt.tens = sat_digit(bus.din_ten, MAX_TENS);
    load_cnt.secs = sat_digit(bus.din_sec, MAX_DIGIT);
  end

  // Strict priority: the highest active control claims the cycle even when
  // the current state ignores it, so lower controls never slip through.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (bus.add30) begin
      if (state_q != ST_PAUSE) begin
        state_d = ST_RUN;
        cnt_d   = add_cnt;
      end
    end else if (bus.pause) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (bus.start) begin
      if ((state_q == ST_IDLE && !cnt_zero) || state_q == ST_PAUSE) begin
        state_d = ST_RUN;
      end
    end else if (bus.load) begin
      if (state_q == ST_IDLE || state_q == ST_DONE) begin
        state_d = ST_IDLE;
        cnt_d   = load_cnt;
      end
    end else if (bus.tick) begin
      if (state_q == ST_RUN) begin
        cnt_d = dec_cnt;
        if (dec_zero) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  assign running_d = (state_d == ST_RUN);
  assign done_d    = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.mins    = cnt_q.mins;
  assign bus.tens    = cnt_q.tens;
  assign bus.secs    = cnt_q.secs;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: hand-computed M:TS and status after each control pulse.
module tb_countdown_timer;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  countdown_timer_if tmr ();

  countdown_timer #(
    .ADD_SECS (30)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {running, done, mins, tens, secs}
  function automatic logic [13:0] obs();
    return {tmr.running, tmr.done, tmr.mins, tmr.tens, tmr.secs};
  endfunction

  function automatic logic [13:0] ev(input logic r, input logic d, input logic [11:0] mts);
    return {r, d, mts};
  endfunction

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got run=%b done=%b %h:%h%h, expected run=%b done=%b %h:%h%h",
               tag, got[13], got[12], got[11:8], got[7:4], got[3:0],
               exp[13], exp[12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic idle_in();
    tmr.tick = 0; tmr.load = 0; tmr.start = 0; tmr.pause = 0;
    tmr.clear = 0; tmr.add30 = 0;
    tmr.din_min = 0; tmr.din_ten = 0; tmr.din_sec = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic do_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
    tmr.load = 1; tmr.din_min = m; tmr.din_ten = t; tmr.din_sec = s;
    cyc();
  endtask

  task automatic do_start(); tmr.start = 1; cyc(); endtask
  task automatic do_pause(); tmr.pause = 1; cyc(); endtask
  task automatic do_clear(); tmr.clear = 1; cyc(); endtask
  task automatic do_add30(); tmr.add30 = 1; cyc(); endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tmr.tick = 1;
      cyc();
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("reset", obs(), ev(0, 0, 12'h000));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Full countdown from 1:45
    do_load(1, 4, 5);   chk("load_145", obs(), ev(0, 0, 12'h145));
    do_start();         chk("start_145", obs(), ev(1, 0, 12'h145));
    ticks(6);           chk("tick6_139", obs(), ev(1, 0, 12'h139));
    ticks(40);          chk("tick46_059", obs(), ev(1, 0, 12'h059));
    ticks(59);          chk("tick105_done", obs(), ev(0, 1, 12'h000));

    // Double borrow and start at zero
    do_load(1, 0, 0);   chk("load_100", obs(), ev(0, 0, 12'h100));
    do_start();
    ticks(1);           chk("borrow_059", obs(), ev(1, 0, 12'h059));
    do_clear();
    do_load(0, 0, 0);
    do_start();         chk("start_zero", obs(), ev(0, 0, 12'h000));

    // Pause / resume
    do_load(0, 1, 0);
    do_start();
    ticks(3);           chk("tick3_007", obs(), ev(1, 0, 12'h007));
    do_pause();         chk("paused", obs(), ev(0, 0, 12'h007));
    ticks(5);           chk("pause_ticks", obs(), ev(0, 0, 12'h007));
    do_add30();         chk("add30_pause", obs(), ev(0, 0, 12'h007));
    do_start();         chk("resume", obs(), ev(1, 0, 12'h007));
    ticks(1);           chk("resume_tick", obs(), ev(1, 0, 12'h006));
    tmr.pause = 1; tmr.tick = 1;
    cyc();              chk("pause_tick", obs(), ev(0, 0, 12'h006));

    // Quick add
    do_clear();
    do_add30();         chk("add30_idle", obs(), ev(1, 0, 12'h030));
    do_clear();
    do_load(9, 4, 5);
    do_add30();         chk("add30_sat", obs(), ev(1, 0, 12'h959));
    do_clear();
    do_load(0, 0, 1);
    do_start();
    ticks(1);           chk("done_001", obs(), ev(0, 1, 12'h000));
    do_add30();         chk("add30_done", obs(), ev(1, 0, 12'h030));
    tmr.add30 = 1; tmr.tick = 1;
    cyc();              chk("add30_tick", obs(), ev(1, 0, 12'h100));
    do_clear();
    do_load(0, 4, 5);
    do_add30();         chk("add30_carry", obs(), ev(1, 0, 12'h115));

    // Load saturation and load ignored while running
    do_clear();
    do_load(12, 7, 11); chk("load_sat", obs(), ev(0, 0, 12'h959));
    do_clear();
    do_load(0, 2, 0);
    do_start();
    do_load(1, 1, 1);   chk("load_in_run", obs(), ev(1, 0, 12'h020));

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", obs(), ev(0, 0, 12'h000));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();              chk("rst_release", obs(), ev(0, 0, 12'h000));
    do_start();         chk("rst_no_retain", obs(), ev(0, 0, 12'h000));

    // clear beats tick in RUN
    do_load(0, 0, 5);
    do_start();
    tmr.clear = 1; tmr.tick = 1;
    cyc();              chk("clear_tick", obs(), ev(0, 0, 12'h000));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
